// File: rtl/sio_l2b_rx.sv
// sio_l2b_rx: receive end of the L2-buffer-to-SIO return path.
// Reassembles write acks (header only) and DMA read returns (header plus
// NBEATS data beats). It checks parity on every header and beat, and hands
// each completed packet to the ingress logic through a valid/ready
// holding register.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no packet in progress; waiting for a header strobe
// DATA   | read header captured; collecting data beats into slot r_cnt
module sio_l2b_rx #(
  parameter int DW     = 32,
  parameter int NBEATS = 16,
  parameter int RD_BIT = 16
) (
  input  logic                 gclk,
  input  logic                 rst,
  input  logic                 l2b_sio_ctag_vld,
  input  logic [DW-1:0]        l2b_sio_data,
  input  logic [1:0]           l2b_sio_parity,
  input  logic                 l2b_sio_ue_err,
  output logic                 pkt_vld,
  input  logic                 pkt_rdy,
  output logic [31:0]          pkt_ctag,
  output logic                 pkt_rd,
  output logic [DW*NBEATS-1:0] pkt_data,
  output logic                 pkt_ue,
  output logic                 pkt_par_err,
  output logic                 ovf_err,
  output logic                 proto_err
);

  localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  logic [0:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_asm_ctag;
  logic [DW*NBEATS-1:0] r_asm_data;
  logic                 r_asm_ue;
  logic                 r_asm_par;

  logic                 w_par_err;
  logic                 w_hdr;
  logic                 w_hdr_ack;
  logic                 w_beat;
  logic                 w_last;
  logic                 w_cmpl;
  logic                 w_load;
  logic                 w_pop;
  logic [31:0]          w_cmpl_ctag;
  logic [DW*NBEATS-1:0] w_cmpl_data;
  logic                 w_cmpl_ue;
  logic                 w_cmpl_par;

  // Classify the current input cycle and build the payload of any packet
  // completing at this edge.
  always_comb begin
    w_par_err = (l2b_sio_parity[1] ^ (^l2b_sio_data[31:16])) |
                (l2b_sio_parity[0] ^ (^l2b_sio_data[15:0]));
    w_hdr     = l2b_sio_ctag_vld;
    w_hdr_ack = l2b_sio_ctag_vld && !l2b_sio_data[RD_BIT];
    w_beat    = (r_state == S_DATA) && !l2b_sio_ctag_vld;
    w_last    = w_beat && (r_cnt == LAST_BEAT);
    w_cmpl    = w_hdr_ack || w_last;
    w_pop     = pkt_vld && pkt_rdy;
    w_load    = w_cmpl && (!pkt_vld || pkt_rdy);

    // A read completes on its last beat, which is still on the bus, so
    // merge it into the assembled image instead of waiting a cycle.
    w_cmpl_ctag = r_asm_ctag;
    w_cmpl_data = r_asm_data;
    w_cmpl_data[int'(r_cnt)*DW +: DW] = l2b_sio_data;
    w_cmpl_ue   = r_asm_ue | l2b_sio_ue_err;
    w_cmpl_par  = r_asm_par | w_par_err;
    if (w_hdr_ack) begin
      w_cmpl_ctag = l2b_sio_data[31:0];
      w_cmpl_data = '0;
      w_cmpl_ue   = 1'b0;
      w_cmpl_par  = w_par_err;
    end
  end

  // Assembly FSM. A header always restarts assembly, even mid-packet;
  // the partial read is simply abandoned.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_asm_ctag <= '0;
      r_asm_data <= '0;
      r_asm_ue   <= 1'b0;
      r_asm_par  <= 1'b0;
    end else if (w_hdr) begin
      r_asm_ctag <= l2b_sio_data[31:0];
      r_asm_data <= '0;
      r_asm_ue   <= 1'b0;
      r_asm_par  <= w_par_err;
      r_cnt      <= '0;
      r_state    <= l2b_sio_data[RD_BIT] ? S_DATA : S_IDLE;
    end else if (w_beat) begin
      r_asm_data[int'(r_cnt)*DW +: DW] <= l2b_sio_data;
      r_asm_ue  <= r_asm_ue | l2b_sio_ue_err;
      r_asm_par <= r_asm_par | w_par_err;
      if (w_last) begin
        r_cnt   <= '0;
        r_state <= S_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Holding register: loads when empty or being popped this cycle,
  // otherwise keeps its contents stable for the consumer.
  always_ff @(posedge gclk) begin
    if (rst) begin
      pkt_vld     <= 1'b0;
      pkt_ctag    <= '0;
      pkt_rd      <= 1'b0;
      pkt_data    <= '0;
      pkt_ue      <= 1'b0;
      pkt_par_err <= 1'b0;
    end else if (w_load) begin
      pkt_vld     <= 1'b1;
      pkt_ctag    <= w_cmpl_ctag;
      pkt_rd      <= w_cmpl_ctag[RD_BIT];
      pkt_data    <= w_cmpl_data;
      pkt_ue      <= w_cmpl_ue;
      pkt_par_err <= w_cmpl_par;
    end else if (w_pop) begin
      pkt_vld <= 1'b0;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge gclk) begin
    if (rst) begin
      ovf_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_cmpl && !w_load)
        ovf_err <= 1'b1;
      if (w_hdr && (r_state == S_DATA))
        proto_err <= 1'b1;
    end
  end

endmodule
